serdes_tx_scheduler: RTL

Upstream feeder and loopback checker for the adaptive UART SERDES top. Buffers bytes from a valid/ready producer in a small FIFO and issues one-cycle `start` pulses with stable `data_8b` and `idle_mode`, one frame at a time. Waits for the SERDES completion pulse (`rx_par_en`), then compares the decoded byte against the byte sent. Keeps saturating pass/fail counters and flags frames that never complete.

---
 rtl/serdes_tx_scheduler_if.sv | 20 ++
 rtl/serdes_tx_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serdes_tx_scheduler_if.sv
// Producer-side byte stream: valid/ready handshake carrying one byte per transfer.
interface serdes_tx_scheduler_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  // Producer drives data/valid and watches ready.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  // Scheduler consumes data/valid and reports whether it can take a byte.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/serdes_tx_scheduler.sv
// Upstream feeder and loopback checker for the adaptive UART SERDES.
// Bytes from the producer are queued in a small FIFO, issued to the SERDES
// one frame at a time, and the decoded byte returned by the SERDES is
// compared with the byte that was sent.
module serdes_tx_scheduler #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 31
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serdes_tx_scheduler_if.slave       in_if,
  input  logic                       cfg_repeat_en,
  output logic                       start,
  output logic [7:0]                 data_8b,
  output logic                       idle_mode,
  input  logic                       rx_par_en,
  input  logic [7:0]                 rx_data,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 ok_count,
  output logic [7:0]                 err_count,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    CHECK     = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      head;
  logic            push;
  logic            pop;
  logic [7:0]      last_sent;
  logic            skip;
  logic [WW-1:0]   wait_cnt;

  // FIFO is full at DEPTH entries; the FSM drains it only from IDLE.
  assign in_if.in_ready = (fifo_level != (AW + 1)'(DEPTH));
  assign push           = in_if.in_valid && in_if.in_ready;
  assign pop            = (state == IDLE) && (fifo_level != '0);
  assign head           = mem[rd_ptr];

  // Storage array: written on every accepted byte, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame sequencer: pop, pulse start, wait for completion or timeout, score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start       <= 1'b0;
      data_8b     <= 8'h00;
      idle_mode   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ok_count    <= 8'h00;
      err_count   <= 8'h00;
      last_sent   <= 8'h00;
      skip        <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      start       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            data_8b   <= head;
            idle_mode <= cfg_repeat_en;
            skip      <= cfg_repeat_en && (head == last_sent);
            last_sent <= head;
            start     <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (rx_par_en) begin
            state <= CHECK;
          end else if (wait_cnt == WW'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (!skip) begin
            if (rx_data == data_8b) begin
              if (ok_count != 8'hFF) begin
                ok_count <= ok_count + 8'd1;
              end
            end else if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
